// File: rtl/itcm_boot_ctrl_pkg.sv
// itcm_boot_ctrl_pkg
//   Shared constants and types for the ITCM boot sequencer.
//   - WORD_WIDTH / PC_WIDTH : core word and program-counter widths
//   - ITCM_AW_DEFAULT       : default ITCM word-address width (8192 words)
//   - itcm_state_e          : boot FSM state encodings
//   - RUNTIME_WR            : 1 when the build defines ITCM_RUNTIME_WR_EN,
//                             which lets the loader write the ITCM during RUN
package itcm_boot_ctrl_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int PC_WIDTH        = 32;
    localparam int ITCM_AW_DEFAULT = 13;

    typedef enum logic [1:0] {
        ITCM_ST_IDLE    = 2'd0,
        ITCM_ST_LOAD    = 2'd1,
        ITCM_ST_RELEASE = 2'd2,
        ITCM_ST_RUN     = 2'd3
    } itcm_state_e;

`ifdef ITCM_RUNTIME_WR_EN
    localparam bit RUNTIME_WR = 1'b1;
`else
    localparam bit RUNTIME_WR = 1'b0;
`endif

endpackage

// File: rtl/itcm_boot_ctrl_cpu_en_delay.sv
// cpu_en_delay
//   Loadable down-counter that times the RELEASE -> RUN transition.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     load       : load load_val this edge (takes priority over counting)
//     load_val   : start value (release delay minus one)
//     en         : count down while high and not yet at zero
//     expired    : counter is at zero
module cpu_en_delay #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          expired
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/itcm_boot_ctrl.sv
// itcm_boot_ctrl
//   Boot sequencer and port arbiter for the single-port instruction TCM.
//   Loads the boot image from the loader, waits RELEASE_DLY cycles, then
//   enables the core and serves its instruction fetches.
//   Build option: define ITCM_RUNTIME_WR_EN to accept loader writes during
//   RUN (writes win over fetches; the losing fetch is stalled).
//   Ports:
//     CLK_IN, RST          : clock, asynchronous active-high reset
//     boot_skip            : image already resident, skip LOAD
//     ld_valid/ld_ready    : loader write handshake
//     ld_addr/ld_data      : loader word address / data
//     ld_last              : final word of the boot image
//     rd_insn_en, pc       : core fetch request and byte address
//     insn, insn_valid     : fetched word (0 when not valid)
//     fetch_stall          : fetch not accepted this cycle
//     ram_*                : SRAM interface (one-cycle read latency)
//     CPU_EN, boot_done    : core enable / boot finished (both high in RUN)
//     ld_cnt               : accepted loader words, saturating at 2^ITCM_AW
//     state_dbg            : current FSM state encoding
//
//   Handshake: a loader word transfers on a rising edge where ld_valid and
//   ld_ready are both high; ld_ready does not depend on ld_valid, and the
//   loader must hold ld_addr/ld_data/ld_last stable while ld_valid is high
//   and ld_ready is low.
module itcm_boot_ctrl
    import itcm_boot_ctrl_pkg::*;
#(
    parameter int ITCM_AW     = ITCM_AW_DEFAULT,
    parameter int RELEASE_DLY = 4
) (
    input  logic                  CLK_IN,
    input  logic                  RST,
    input  logic                  boot_skip,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ITCM_AW-1:0]    ld_addr,
    input  logic [WORD_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    input  logic                  rd_insn_en,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic [WORD_WIDTH-1:0] insn,
    output logic                  insn_valid,
    output logic                  fetch_stall,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ITCM_AW-1:0]    ram_addr,
    output logic [WORD_WIDTH-1:0] ram_wdata,
    input  logic [WORD_WIDTH-1:0] ram_rdata,
    output logic                  CPU_EN,
    output logic                  boot_done,
    output logic [ITCM_AW:0]      ld_cnt,
    output logic [1:0]            state_dbg
);

    localparam logic [7:0]       DLY_M1     = 8'(RELEASE_DLY - 1);
    localparam logic [ITCM_AW:0] LD_CNT_MAX = {1'b1, {ITCM_AW{1'b0}}};

    itcm_state_e state, next_state;

    logic               ld_xfer;
    logic               fetch_go;
    logic               dly_load;
    logic               dly_expired;
    logic [ITCM_AW-1:0] fetch_addr;
    logic               unused_pc;

    // Word address; byte offset and bits above the ITCM are dropped, so
    // out-of-range fetches alias modulo the ITCM size.
    assign fetch_addr = pc[ITCM_AW+1:2];
    assign unused_pc  = ^{pc[1:0], pc[PC_WIDTH-1:ITCM_AW+2]};

    assign ld_xfer = ld_valid && ld_ready;

    // ---------------- state register ----------------
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state <= ITCM_ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            ITCM_ST_IDLE:    next_state = boot_skip ? ITCM_ST_RELEASE : ITCM_ST_LOAD;
            ITCM_ST_LOAD:    if (ld_xfer && ld_last) next_state = ITCM_ST_RELEASE;
            ITCM_ST_RELEASE: if (dly_expired) next_state = ITCM_ST_RUN;
            ITCM_ST_RUN:     next_state = ITCM_ST_RUN;
            default:         next_state = ITCM_ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        ld_ready    = 1'b0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        fetch_stall = 1'b0;
        fetch_go    = 1'b0;
        case (state)
            ITCM_ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ram_cs    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = ld_addr;
                    ram_wdata = ld_data;
                end
            end
            ITCM_ST_RUN: begin
                ld_ready = RUNTIME_WR;
                if (RUNTIME_WR && ld_valid) begin
                    // Runtime write owns the single SRAM port this cycle.
                    ram_cs      = 1'b1;
                    ram_we      = 1'b1;
                    ram_addr    = ld_addr;
                    ram_wdata   = ld_data;
                    fetch_stall = rd_insn_en;
                end else if (rd_insn_en) begin
                    ram_cs   = 1'b1;
                    ram_addr = fetch_addr;
                    fetch_go = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign CPU_EN    = (state == ITCM_ST_RUN);
    assign boot_done = (state == ITCM_ST_RUN);
    assign state_dbg = state;

    // ---------------- release delay ----------------
    assign dly_load = (next_state == ITCM_ST_RELEASE) && (state != ITCM_ST_RELEASE);

    cpu_en_delay #(.CW(8)) u_cpu_en_delay (
        .clk      (CLK_IN),
        .rst      (RST),
        .load     (dly_load),
        .load_val (DLY_M1),
        .en       (state == ITCM_ST_RELEASE),
        .expired  (dly_expired)
    );

    // ---------------- loader word counter ----------------
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            ld_cnt <= '0;
        end else if (ld_xfer && (ld_cnt != LD_CNT_MAX)) begin
            ld_cnt <= ld_cnt + 1'b1;
        end
    end

    // ---------------- fetch return ----------------
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            insn_valid <= 1'b0;
        end else begin
            insn_valid <= fetch_go;
        end
    end

    assign insn = insn_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_itcm_boot_ctrl.sv
// tb_itcm_boot_ctrl
//   Directed bench for itcm_boot_ctrl with a behavioural one-cycle SRAM.
//   Runs with or without ITCM_RUNTIME_WR_EN defined.
module tb_itcm_boot_ctrl;

    localparam int AW = 13;
    localparam int WW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          boot_skip = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [WW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          rd_insn_en = 1'b0;
    logic [31:0]   pc = '0;
    logic [WW-1:0] insn;
    logic          insn_valid;
    logic          fetch_stall;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_wdata;
    logic [WW-1:0] ram_rdata = '0;
    logic          cpu_en;
    logic          boot_done;
    logic [AW:0]   ld_cnt;
    logic [1:0]    state_dbg;

    int checks = 0;
    int failures = 0;

    itcm_boot_ctrl #(.ITCM_AW(AW), .RELEASE_DLY(4)) dut (
        .CLK_IN      (clk),
        .RST         (rst),
        .boot_skip   (boot_skip),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .rd_insn_en  (rd_insn_en),
        .pc          (pc),
        .insn        (insn),
        .insn_valid  (insn_valid),
        .fetch_stall (fetch_stall),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .CPU_EN      (cpu_en),
        .boot_done   (boot_done),
        .ld_cnt      (ld_cnt),
        .state_dbg   (state_dbg)
    );

    // ---------------- SRAM model (with bench-side preload port) ----------------
    logic [WW-1:0] mem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [WW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_cs && !ram_we) ram_rdata <= mem[ram_addr];
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [WW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic ld_word(input logic [AW-1:0] a, input logic [WW-1:0] d, input logic last);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // Holds reset for two cycles, checks reset values, releases mid-cycle.
    task automatic do_reset(input logic skip);
        rst = 1'b1; boot_skip = skip; ld_valid = 1'b0; ld_last = 1'b0; rd_insn_en = 1'b0;
        tick();
        tick();
        check("rst_cpu_en", 64'(cpu_en), 64'd0);
        check("rst_outputs",
              64'({boot_done, ld_ready, insn_valid, fetch_stall, ram_cs, ram_we}), 64'd0);
        check("rst_insn", 64'(insn), 64'd0);
        check("rst_ram_bus", 64'({ram_addr, ram_wdata}), 64'd0);
        check("rst_ld_cnt", 64'(ld_cnt), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_ld_ready", 64'(ld_ready), 64'd0);
        check("idle_state", 64'(state_dbg), 64'd0);
    endtask

    task automatic wait_release(input string tag);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check({tag, "_cpu_en_early"}, 64'(cpu_en), 64'd0);
        end
        tick();
        check({tag, "_cpu_en"}, 64'(cpu_en), 64'd1);
        check({tag, "_boot_done"}, 64'(boot_done), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Preload SRAM while reset holds the DUT off the bus.
        rst = 1'b1;
        preload(13'd0, 32'hAAAA_0000);
        preload(13'd1, 32'hBBBB_1111);
        preload(13'd2, 32'hCCCC_2222);
        preload(13'd5, 32'h1111_1111);

        // ---- 1: three-word load, release delay, fetch ----
        do_reset(1'b0);
        tick();
        check("t1_load_ready", 64'(ld_ready), 64'd1);
        ld_valid = 1'b1; ld_addr = 13'd0; ld_data = 32'h0000_0013; #1;
        check("t1_wr_bus", 64'({ram_cs, ram_we, ram_addr}), 64'({1'b1, 1'b1, 13'd0}));
        ld_word(13'd0, 32'h0000_0013, 1'b0);
        ld_word(13'd1, 32'h0010_0093, 1'b0);
        rd_insn_en = 1'b1; pc = 32'h0; #1;
        check("t1_load_fetch_ignored", 64'({ram_cs, fetch_stall}), 64'd0);
        rd_insn_en = 1'b0;
        ld_word(13'd2, 32'h0000_006F, 1'b1);
        check("t1_ld_cnt", 64'(ld_cnt), 64'd3);
        check("t1_release_ld_ready", 64'(ld_ready), 64'd0);
        wait_release("t1");
        rd_insn_en = 1'b1; pc = 32'h8; #1;
        check("t1_fetch_bus", 64'({ram_cs, ram_we, ram_addr}), 64'({1'b1, 1'b0, 13'd2}));
        tick();
        rd_insn_en = 1'b0;
        check("t1_insn_valid", 64'(insn_valid), 64'd1);
        check("t1_insn", 64'(insn), 64'h0000_006F);
        tick();
        check("t1_idle_insn_valid", 64'(insn_valid), 64'd0);
        check("t1_idle_insn", 64'(insn), 64'd0);

        // ---- 2: boot_skip with preloaded SRAM ----
        // Re-preload word 0..2 (test 1 overwrote them).
        rst = 1'b1;
        preload(13'd0, 32'hAAAA_0000);
        preload(13'd1, 32'hBBBB_1111);
        preload(13'd2, 32'hCCCC_2222);
        do_reset(1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t2_no_ld_ready", 64'(ld_ready), 64'd0);
            check("t2_cpu_en_early", 64'(cpu_en), 64'd0);
        end
        tick();
        check("t2_cpu_en", 64'(cpu_en), 64'd1);
        rd_insn_en = 1'b1; pc = 32'h0;
        tick();
        check("t2_insn0", 64'({insn_valid, insn}), 64'({1'b1, 32'hAAAA_0000}));
        pc = 32'h4;
        tick();
        check("t2_insn1", 64'({insn_valid, insn}), 64'({1'b1, 32'hBBBB_1111}));
        pc = 32'h8;
        tick();
        check("t2_insn2", 64'({insn_valid, insn}), 64'({1'b1, 32'hCCCC_2222}));
        pc = 32'h0000_8007;   // word 0x2001 aliases to word 1, byte offset ignored
        tick();
        check("t2_alias", 64'({insn_valid, insn}), 64'({1'b1, 32'hBBBB_1111}));
        pc = 32'h0;
        #2;
        rst = 1'b1;           // asynchronous mid-run reset
        #1;
        check("t2_async_cpu_en", 64'(cpu_en), 64'd0);
        check("t2_async_insn", 64'({insn_valid, insn}), 64'd0);
        rd_insn_en = 1'b0;

        // ---- 3: reset mid-LOAD, then a fresh load ----
        do_reset(1'b0);
        tick();
        ld_word(13'd10, 32'hA0A0_A0A0, 1'b0);
        ld_word(13'd11, 32'hB0B0_B0B0, 1'b0);
        check("t3_ld_cnt_pre", 64'(ld_cnt), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t3_async_ld_cnt", 64'(ld_cnt), 64'd0);
        check("t3_async_state", 64'({state_dbg, ld_ready, cpu_en}), 64'd0);
        do_reset(1'b0);
        tick();
        ld_word(13'd3, 32'h3333_3333, 1'b1);
        check("t3_ld_cnt", 64'(ld_cnt), 64'd1);
        wait_release("t3");
        rd_insn_en = 1'b1; pc = 32'h28;
        tick();
        check("t3_kept_word", 64'({insn_valid, insn}), 64'({1'b1, 32'hA0A0_A0A0}));
        pc = 32'hC;
        tick();
        check("t3_new_word", 64'({insn_valid, insn}), 64'({1'b1, 32'h3333_3333}));

        // ---- 4: loader write coinciding with a fetch in RUN ----
        ld_valid = 1'b1; ld_addr = 13'd5; ld_data = 32'hDEAD_BEEF;
        rd_insn_en = 1'b1; pc = 32'h14; #1;
`ifdef ITCM_RUNTIME_WR_EN
        check("t4_stall", 64'({ld_ready, fetch_stall, ram_we}), 64'b111);
        tick();
        ld_valid = 1'b0;
        check("t4_no_valid", 64'({insn_valid, insn}), 64'd0);
        #1;
        check("t4_retry_accepted", 64'({fetch_stall, ram_cs, ram_we}), 64'b010);
        tick();
        check("t4_retry", 64'({insn_valid, insn}), 64'({1'b1, 32'hDEAD_BEEF}));
`else
        check("t4_no_write", 64'({ld_ready, fetch_stall, ram_we}), 64'd0);
        check("t4_fetch_bus", 64'({ram_cs, ram_addr}), 64'({1'b1, 13'd5}));
        tick();
        check("t4_fetch0", 64'({insn_valid, insn}), 64'({1'b1, 32'h1111_1111}));
        tick();
        check("t4_fetch1", 64'({insn_valid, insn, ld_ready}), 64'({1'b1, 32'h1111_1111, 1'b0}));
        ld_valid = 1'b0;
`endif
        rd_insn_en = 1'b0;
        tick();
        check("t4_idle_insn", 64'({insn_valid, insn}), 64'd0);

        // ---- 5: ld_cnt saturation (duplicate addresses overwrite) ----
        do_reset(1'b0);
        tick();
        for (int i = 0; i < (1 << AW); i++) begin
            ld_word(AW'(i), 32'(i), 1'b0);
        end
        check("t5_ld_cnt_full", 64'(ld_cnt), 64'h2000);
        ld_word(13'd7, 32'h7777_7777, 1'b0);
        check("t5_ld_cnt_sat", 64'(ld_cnt), 64'h2000);
        ld_word(13'd0, 32'h0, 1'b1);
        check("t5_ld_cnt_last", 64'(ld_cnt), 64'h2000);
        wait_release("t5");
        rd_insn_en = 1'b1; pc = 32'h1C;
        tick();
        rd_insn_en = 1'b0;
        check("t5_overwrite", 64'({insn_valid, insn}), 64'({1'b1, 32'h7777_7777}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/itcm_boot_ctrl.md
# itcm_boot_ctrl

Boot sequencer and port arbiter for the instruction TCM inside `soc_top`. Accepts image words from the loader (UART loader or debug port), writes them into the single-port ITCM SRAM, and raises `CPU_EN` only after loading completes and a fixed release delay expires. During run it serves core fetches (`rd_insn_en`/`pc` → `insn`) and, optionally, arbitrates runtime loader writes against those fetches.

## Interface
- `ITCM_AW`, 13: ITCM word-address width (8192 words).
- `RELEASE_DLY`, 4: cycles between load completion and `CPU_EN` rising; legal range 1..255.
- `CLK_IN  in  1`: the single clock, rising edge.
- `RST  in  1`: reset, asynchronous and active-high.
- `boot_skip  in  1`: sampled in IDLE; 1 means the image is already resident, so LOAD is skipped.
- `ld_valid  in  1`, `ld_ready  out  1`: loader write handshake; a write transfers when both are high at the clock edge.
- `ld_addr  in  ITCM_AW`: loader word address.
- `ld_data  in  WORD_WIDTH`: loader write data.
- `ld_last  in  1`: qualifies the final word of the boot image.
- `rd_insn_en  in  1`: core fetch request.
- `pc  in  PC_WIDTH`: fetch byte address; only `pc[ITCM_AW+1:2]` is used.
- `insn  out  WORD_WIDTH`: fetched word; 0 whenever `insn_valid`=0.
- `insn_valid  out  1`: `insn` is valid in this cycle.
- `fetch_stall  out  1`: the fetch was not accepted this cycle, so the core must hold `pc`.
- `ram_cs, ram_we  out  1`: SRAM select and write enable.
- `ram_addr  out  ITCM_AW`: SRAM word address.
- `ram_wdata  out  WORD_WIDTH`: SRAM write data.
- `ram_rdata  in  WORD_WIDTH`: SRAM read data, one-cycle read latency.
- `CPU_EN  out  1`: core enable.
- `boot_done  out  1`: high in RUN.
- `ld_cnt  out  ITCM_AW+1`: number of accepted loader words; saturates at 2^ITCM_AW.

## Operation
- FSM states: IDLE, LOAD, RELEASE, RUN. All state is reset by `RST` to IDLE.
- IDLE: the FSM spends exactly one cycle here after reset. If `boot_skip`=1 it goes to RELEASE, otherwise to LOAD. `ld_ready`=0.
- LOAD:
  - `ld_ready`=1; each transfer drives `ram_cs`=`ram_we`=1 with `ld_addr`/`ld_data`, and `ld_cnt` increments.
  - A transfer with `ld_last`=1 moves the FSM to RELEASE.
  - `rd_insn_en` is ignored and `fetch_stall`=0.
- RELEASE: the delay counter loads `RELEASE_DLY-1` on entry and decrements each cycle. At 0 the FSM goes to RUN. `ld_ready`=0.
- RUN:
  - `CPU_EN`=1 and `boot_done`=1.
  - A fetch drives `ram_cs`=1, `ram_we`=0, `ram_addr`=`pc[ITCM_AW+1:2]`.
  - One cycle later `insn_valid`=1 and `insn`=`ram_rdata`.
- Duplicate `ld_addr` values in LOAD overwrite the earlier word. `ld_cnt` still counts every transfer and stops at 2^ITCM_AW (no wrap).
- `pc[1:0]` is ignored. Fetch addresses beyond the ITCM alias modulo 2^ITCM_AW words.
- Asserting `RST` mid-load or mid-run immediately clears `CPU_EN`, `insn_valid`, `ld_cnt` and the FSM state. SRAM contents are not cleared.

## Timing
- Reset values: `CPU_EN`=0, `boot_done`=0, `ld_ready`=0, `insn_valid`=0, `insn`=0, `fetch_stall`=0, all `ram_*` outputs=0, `ld_cnt`=0.
- `ram_*`, `ld_ready` and `fetch_stall` are combinational from state and inputs. `insn_valid` is registered.
- Fetch latency: request in cycle N gives `insn_valid` in cycle N+1. Back-to-back fetches sustain 1 word per cycle.
- The `ld_last` transfer is at edge E. RELEASE starts at E. `CPU_EN` rises at edge E+`RELEASE_DLY`.
- With `boot_skip`, the first cycle after reset deassertion is IDLE, and `CPU_EN` rises `RELEASE_DLY` edges after leaving IDLE.

## Configuration
- Macro `ITCM_RUNTIME_WR_EN`.
- Defined: in RUN, `ld_ready`=1 and loader writes are accepted, with priority over fetch.
  - When `ld_valid` and `rd_insn_en` coincide, the write goes to SRAM and `fetch_stall`=1.
  - `insn_valid`=0 in the following cycle.
  - The core retries the fetch and is served in the next free cycle.
- Undefined: in RUN, `ld_ready`=0, `fetch_stall` is tied to 0, and loader traffic is ignored.

## Structure
- Shared constants belong in `define.v`: existing `WORD_WIDTH` and `PC_WIDTH`, new `ITCM_AW_DEFAULT`, and the FSM state encodings `ITCM_ST_IDLE`/`LOAD`/`RELEASE`/`RUN`.
- One sub-module is natural: `cpu_en_delay`, a loadable down-counter that produces the RELEASE→RUN strobe.

## Test plan
- Load 3 words (addr 0/1/2 = 0x00000013, 0x00100093, 0x0000006F), last on the third → `ld_cnt`=3; `CPU_EN` rises exactly 4 edges after the third transfer. Fetch at pc 0x8 → `insn`=0x0000006F one cycle later.
- `boot_skip`=1 with SRAM preloaded → no `ld_ready` pulse; `CPU_EN` high 5 edges after reset release. Fetches at pc 0,4,8 return the preloaded words on consecutive cycles.
- `RST` pulsed mid-LOAD after 2 words → `CPU_EN`/`ld_cnt` go to 0 asynchronously. A fresh load then completes normally.
- RUN with `ITCM_RUNTIME_WR_EN`: `ld_valid` and `rd_insn_en` in the same cycle (addr 5 = 0xDEADBEEF, pc 0x14) → `fetch_stall`=1. Retried fetch returns 0xDEADBEEF.
- RUN without the macro: `ld_valid` held → `ld_ready`=0, SRAM not written, fetches uninterrupted.
- `rd_insn_en`=0 in RUN → `insn`=0 and `insn_valid`=0 on the next cycle.
